xls_matmul_stream: RTL and testbench



---
 rtl/xls_matmul_pkg.sv | 33 +++
 rtl/xls_matmul_stream_if.sv | 30 +++
 rtl/xls_matmul_dot.sv | 27 ++
 rtl/xls_matmul_stream.sv | 105 ++++++++++
 tb/tb_xls_matmul_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xls_matmul_pkg.sv
// Shared defaults and arithmetic helpers for the streaming NxN matrix-multiply block.
// Helpers work on a 64-bit container; callers pass the live element width w.
package xls_matmul_pkg;

  localparam int DEF_N = 2;
  localparam int DEF_W = 32;

  function automatic int elem_off(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

  function automatic logic [63:0] wmask(input int w);
    if (w >= 64) begin
      return {64{1'b1}};
    end else begin
      return (64'd1 << w) - 64'd1;
    end
  endfunction

  function automatic logic [63:0] wrap_add(input logic [63:0] x, input logic [63:0] y, input int w);
    return (x + y) & wmask(w);
  endfunction

  // Sign-extend both operands from bit w-1, multiply, keep the low w bits.
  function automatic logic [63:0] smul_trunc(input logic [63:0] x, input logic [63:0] y, input int w);
    logic signed [63:0] xs;
    logic signed [63:0] ys;
    xs = $signed(x << (64 - w)) >>> (64 - w);
    ys = $signed(y << (64 - w)) >>> (64 - w);
    return 64'(xs * ys) & wmask(w);
  endfunction

endpackage

// File: rtl/xls_matmul_stream_if.sv
// Operand/result stream bundle for xls_matmul_stream; the slave side is the compute block.
interface xls_matmul_stream_if
  import xls_matmul_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);
  localparam int MAT_W = N * N * W;

  logic               in_valid;
  logic               in_ready;
  logic               acc_en;
  logic [MAT_W-1:0]   a;
  logic [MAT_W-1:0]   b;
  logic [MAT_W-1:0]   c_in;
  logic               out_valid;
  logic               out_ready;
  logic [3*MAT_W-1:0] out;

  modport master (
    output in_valid, acc_en, a, b, c_in, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, acc_en, a, b, c_in, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/xls_matmul_dot.sv
// One output element: N pre-truncated products summed, plus an optional addend.
module xls_matmul_dot
  import xls_matmul_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic [N*W-1:0] prods,
  input  logic [W-1:0]   addend,
  input  logic           acc_en,
  output logic [W-1:0]   sum
);

  // W-bit accumulator gives the modulo-2^W wrap for free.
  always_comb begin
    sum = '0;
    if (acc_en) begin
      sum = addend;
    end else begin
      sum = '0;
    end
    for (int k = 0; k < N; k++) begin
      sum = sum + prods[k*W +: W];
    end
  end

endmodule

// File: rtl/xls_matmul_stream.sv
// Three-stage C = A*B (+ C_in) pipeline with a single global enable driven by the output stall.
module xls_matmul_stream
  import xls_matmul_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input logic                clk,
  input logic                rst_n,
  xls_matmul_stream_if.slave bus
);

  localparam int MAT_W  = N * N * W;
  localparam int PROD_W = N * N * N * W;

  logic                en_s;
  logic                v1_r;
  logic                v2_r;
  logic                out_valid_r;
  logic                acc1_r;
  logic                acc2_r;
  logic [MAT_W-1:0]    a1_r;
  logic [MAT_W-1:0]    b1_r;
  logic [MAT_W-1:0]    c1_r;
  logic [MAT_W-1:0]    a2_r;
  logic [MAT_W-1:0]    b2_r;
  logic [MAT_W-1:0]    c2_r;
  logic [PROD_W-1:0]   prod_s;
  logic [PROD_W-1:0]   prod_r;
  logic [MAT_W-1:0]    sum_s;
  logic [3*MAT_W-1:0]  out_r;

  assign en_s          = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;

  // Product (i,j,k) = A[i][k]*B[k][j] sits at slot (i*N+j)*N+k so each dot gets a contiguous slice.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      for (genvar k = 0; k < N; k++) begin : g_term
        assign prod_s[((i*N + j)*N + k)*W +: W] =
          $signed(a1_r[elem_off(i, k, N, W) +: W]) * $signed(b1_r[elem_off(k, j, N, W) +: W]);
      end

      xls_matmul_dot #(
        .N (N),
        .W (W)
      ) u_dot (
        .prods  (prod_r[(i*N + j)*N*W +: N*W]),
        .addend (c2_r[elem_off(i, j, N, W) +: W]),
        .acc_en (acc2_r),
        .sum    (sum_s[elem_off(i, j, N, W) +: W])
      );
    end
  end

  // Stage 1: capture the operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      acc1_r <= 1'b0;
      a1_r   <= '0;
      b1_r   <= '0;
      c1_r   <= '0;
    end else if (en_s) begin
      v1_r   <= bus.in_valid;
      acc1_r <= bus.acc_en;
      a1_r   <= bus.a;
      b1_r   <= bus.b;
      c1_r   <= bus.c_in;
    end
  end

  // Stage 2: truncated products, with A/B/C_in carried alongside for the output echo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      acc2_r <= 1'b0;
      prod_r <= '0;
      a2_r   <= '0;
      b2_r   <= '0;
      c2_r   <= '0;
    end else if (en_s) begin
      v2_r   <= v1_r;
      acc2_r <= acc1_r;
      prod_r <= prod_s;
      a2_r   <= a1_r;
      b2_r   <= b1_r;
      c2_r   <= c1_r;
    end
  end

  // Stage 3: result register that drives the output tuple directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else if (en_s) begin
      out_valid_r <= v2_r;
      out_r       <= {a2_r, b2_r, sum_s};
    end
  end

endmodule

// File: tb/tb_xls_matmul_stream.sv
// Self-checking bench: directed cases plus randomized traffic for N=2/W=32 and N=3/W=16 instances.
module tb_xls_matmul_stream;
  import xls_matmul_pkg::*;

  localparam int N2 = 2;
  localparam int W2 = 32;
  localparam int MW2 = N2 * N2 * W2;
  localparam int N3 = 3;
  localparam int W3 = 16;
  localparam int MW3 = N3 * N3 * W3;

  typedef logic [MW2-1:0]   mat2_t;
  typedef logic [3*MW2-1:0] res2_t;
  typedef logic [MW3-1:0]   mat3_t;
  typedef logic [3*MW3-1:0] res3_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res2_t q2[$];
  res3_t q3[$];

  always #5 clk = ~clk;

  xls_matmul_stream_if #(.N(N2), .W(W2)) bus2 ();
  xls_matmul_stream_if #(.N(N3), .W(W3)) bus3 ();

  xls_matmul_stream #(.N(N2), .W(W2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  xls_matmul_stream #(.N(N3), .W(W3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  a_hold2: assert property (@(posedge clk) disable iff (!rst_n)
    (bus2.in_valid && !bus2.in_ready) |=> (bus2.in_valid && $stable(bus2.a) && $stable(bus2.b) && $stable(bus2.c_in)))
    else $error("operand hold rule broken on bus2");
  a_hold3: assert property (@(posedge clk) disable iff (!rst_n)
    (bus3.in_valid && !bus3.in_ready) |=> (bus3.in_valid && $stable(bus3.a) && $stable(bus3.b) && $stable(bus3.c_in)))
    else $error("operand hold rule broken on bus3");

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // C = A*B (+C_in) element by element, any n/w up to 4x4x64.
  function automatic logic [1023:0] model_c(input logic [1023:0] a, input logic [1023:0] b,
                                            input logic [1023:0] c, input logic acc, input int n, input int w);
    logic [1023:0] r;
    logic [1023:0] t;
    logic [63:0]   s, x, y;
    r = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        t = c >> elem_off(i, j, n, w);
        s = acc ? (t[63:0] & wmask(w)) : 64'd0;
        for (int k = 0; k < n; k++) begin
          t = a >> elem_off(i, k, n, w);
          x = t[63:0];
          t = b >> elem_off(k, j, n, w);
          y = t[63:0];
          s = wrap_add(s, smul_trunc(x, y, w), w);
        end
        r = r | (1024'(s) << elem_off(i, j, n, w));
      end
    end
    return r;
  endfunction

  function automatic res2_t exp2(input mat2_t a, input mat2_t b, input mat2_t c, input logic acc);
    logic [1023:0] r;
    r = model_c(1024'(a), 1024'(b), 1024'(c), acc, N2, W2);
    return {a, b, r[MW2-1:0]};
  endfunction

  function automatic res3_t exp3(input mat3_t a, input mat3_t b, input mat3_t c, input logic acc);
    logic [1023:0] r;
    r = model_c(1024'(a), 1024'(b), 1024'(c), acc, N3, W3);
    return {a, b, r[MW3-1:0]};
  endfunction

  function automatic mat2_t rnd2();
    mat2_t m;
    logic [31:0] e;
    for (int k = 0; k < N2 * N2; k++) begin
      e = $urandom;
      case ($urandom_range(0, 7))
        0: e = 32'h8000_0000;
        1: e = 32'hFFFF_FFFF;
        default: e = e;
      endcase
      m[k*W2 +: W2] = e;
    end
    return m;
  endfunction

  function automatic mat3_t rnd3();
    mat3_t m;
    for (int k = 0; k < N3 * N3; k++) m[k*W3 +: W3] = 16'($urandom);
    return m;
  endfunction

  // One clock of the N=2 stream: drive at negedge, observe just before the rising edge.
  task automatic cyc2(input logic v, input logic acc, input mat2_t a, input mat2_t b, input mat2_t c,
                      input logic ordy, output logic ok, output logic x, output res2_t d,
                      output logic ir, output logic ov);
    bus2.in_valid = v; bus2.acc_en = acc; bus2.a = a; bus2.b = b; bus2.c_in = c; bus2.out_ready = ordy;
    #1;
    ir = bus2.in_ready; ov = bus2.out_valid; d = bus2.out;
    ok = v && ir; x = ov && ordy;
    @(negedge clk);
  endtask

  task automatic cyc3(input logic v, input logic acc, input mat3_t a, input mat3_t b, input mat3_t c,
                      input logic ordy, output logic ok, output logic x, output res3_t d,
                      output logic ir, output logic ov);
    bus3.in_valid = v; bus3.acc_en = acc; bus3.a = a; bus3.b = b; bus3.c_in = c; bus3.out_ready = ordy;
    #1;
    ir = bus3.in_ready; ov = bus3.out_valid; d = bus3.out;
    ok = v && ir; x = ov && ordy;
    @(negedge clk);
  endtask

  // Offer one set, then idle; lat = cycles from the accepting cycle to the first output transfer.
  task automatic send_one2(input logic acc, input mat2_t a, input mat2_t b, input mat2_t c,
                           output logic ok, output int lat, output res2_t got);
    logic o2, x, ir, ov;
    res2_t d;
    lat = -1; got = '0;
    cyc2(1'b1, acc, a, b, c, 1'b1, ok, x, d, ir, ov);
    for (int n = 1; n <= 8; n++) begin
      cyc2(1'b0, acc, a, b, c, 1'b1, o2, x, d, ir, ov);
      if (x && lat < 0) begin lat = n; got = d; end
    end
  endtask

  task automatic test_reset();
    bus2.in_valid = 1'b0; bus2.acc_en = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c_in = '0; bus2.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.acc_en = 1'b0; bus3.a = '0; bus3.b = '0; bus3.c_in = '0; bus3.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got %b want 0", bus2.out_valid); end
    checks++; if (bus2.out !== '0) begin errors++; $display("FAIL reset_out2 got %h want 0", bus2.out); end
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready2 got %b want 1", bus2.in_ready); end
    checks++; if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got %b want 0", bus3.out_valid); end
    checks++; if (bus3.out !== '0) begin errors++; $display("FAIL reset_out3 got %h want 0", bus3.out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    mat2_t a, b, ce;
    res2_t got;
    logic ok;
    int lat;
    a  = {32'd4, 32'd3, 32'd2, 32'd1};
    b  = {32'd8, 32'd7, 32'd6, 32'd5};
    ce = {32'd50, 32'd43, 32'd22, 32'd19};
    send_one2(1'b0, a, b, rnd2(), ok, lat, got);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_first_accept got %b want 1", ok); end
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    checks++; if (got[MW2-1:0] !== ce) begin errors++; $display("FAIL basic_c got %h want %h", got[MW2-1:0], ce); end
    checks++; if (got[3*MW2-1:2*MW2] !== a) begin errors++; $display("FAIL basic_a_echo got %h want %h", got[3*MW2-1:2*MW2], a); end
    checks++; if (got[2*MW2-1:MW2] !== b) begin errors++; $display("FAIL basic_b_echo got %h want %h", got[2*MW2-1:MW2], b); end
  endtask

  task automatic test_signed_wrap();
    mat2_t a, b, ce;
    res2_t got;
    logic ok;
    int lat;
    a  = {32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
    b  = {32'h8000_0000, 32'd0, 32'd0, 32'h7FFF_FFFF};
    ce = {32'h8000_0000, 32'd0, 32'd0, 32'h8000_0001};
    send_one2(1'b0, a, b, '0, ok, lat, got);
    checks++; if (lat != 3) begin errors++; $display("FAIL signed_latency got %0d want 3", lat); end
    checks++; if (got[31:0] !== 32'h8000_0001) begin errors++; $display("FAIL signed_c00 got %h want 80000001", got[31:0]); end
    checks++; if (got[127:96] !== 32'h8000_0000) begin errors++; $display("FAIL signed_c11 got %h want 80000000", got[127:96]); end
    checks++; if (got[MW2-1:0] !== ce) begin errors++; $display("FAIL signed_c got %h want %h", got[MW2-1:0], ce); end
  endtask

  task automatic test_accumulate();
    mat2_t a, b, c;
    res2_t d;
    res2_t r[2];
    int idx[2];
    int n;
    logic ok1, ok2, o, x, ir, ov;
    a = {32'd1, 32'd0, 32'd0, 32'd1};
    b = {32'd5, 32'd4, 32'd3, 32'd2};
    c = {4{32'd10}};
    n = 0;
    cyc2(1'b1, 1'b1, a, b, c, 1'b1, ok1, x, d, ir, ov);
    cyc2(1'b1, 1'b0, a, b, c, 1'b1, ok2, x, d, ir, ov);
    for (int k = 2; k < 10; k++) begin
      cyc2(1'b0, 1'b0, a, b, c, 1'b1, o, x, d, ir, ov);
      if (x && n < 2) begin r[n] = d; idx[n] = k; n++; end
    end
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL acc_accept got %b%b want 11", ok1, ok2); end
    checks++; if (n != 2) begin errors++; $display("FAIL acc_count got %0d want 2", n); end
    if (n == 2) begin
      checks++; if (r[0][MW2-1:0] !== {32'd15, 32'd14, 32'd13, 32'd12}) begin errors++; $display("FAIL acc_on got %h want 0000000f0000000e0000000d0000000c", r[0][MW2-1:0]); end
      checks++; if (r[1][MW2-1:0] !== b) begin errors++; $display("FAIL acc_off got %h want %h", r[1][MW2-1:0], b); end
      checks++; if (idx[0] != 3 || idx[1] != 4) begin errors++; $display("FAIL acc_timing got %0d,%0d want 3,4", idx[0], idx[1]); end
    end
  endtask

  task automatic test_backpressure();
    mat2_t sa[5], sb[5], sc[5];
    logic sacc[5];
    res2_t d, held, e;
    logic ok, x, ir, ov, v, ordy;
    int sent, got, s;
    q2.delete(); sent = 0; got = 0; held = '0;
    for (int k = 0; k < 5; k++) begin sa[k] = rnd2(); sb[k] = rnd2(); sc[k] = rnd2(); sacc[k] = 1'($urandom_range(0, 1)); end
    for (int k = 0; k < 40 && got < 5; k++) begin
      ordy = !(k >= 3 && k <= 8);
      v = (sent < 5);
      s = (sent < 5) ? sent : 4;
      cyc2(v, sacc[s], sa[s], sb[s], sc[s], ordy, ok, x, d, ir, ov);
      if (k >= 3 && k <= 8) begin
        if (k == 3) held = d;
        checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", k, ir); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", k, ov); end
        if (k > 3) begin
          checks++; if (d !== held) begin errors++; $display("FAIL bp_out_stable cyc %0d got %h want %h", k, d, held); end
        end
      end
      if (x) begin
        checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL bp_extra got %h want none", d); end
        else begin e = q2.pop_front(); if (d !== e) begin errors++; $display("FAIL bp_order got %h want %h", d, e); end end
        got++;
      end
      if (ok) begin q2.push_back(exp2(sa[s], sb[s], sc[s], sacc[s])); sent++; end
    end
    checks++; if (got != 5 || q2.size() != 0) begin errors++; $display("FAIL bp_count got %0d want 5", got); end
    for (int k = 0; k < 4; k++) begin
      cyc2(1'b0, 1'b0, '0, '0, '0, 1'b1, ok, x, d, ir, ov);
      checks++; if (x !== 1'b0) begin errors++; $display("FAIL bp_duplicate got %h want none", d); end
    end
  endtask

  task automatic test_reset_midflight();
    mat2_t a, b, c;
    res2_t d, got;
    logic ok1, ok2, ok, x, ir, ov;
    int stale, lat;
    cyc2(1'b1, 1'b0, rnd2(), rnd2(), rnd2(), 1'b1, ok1, x, d, ir, ov);
    cyc2(1'b1, 1'b1, rnd2(), rnd2(), rnd2(), 1'b1, ok2, x, d, ir, ov);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL rst_mid_accept got %b%b want 11", ok1, ok2); end
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", bus2.out_valid); end
    checks++; if (bus2.out !== '0) begin errors++; $display("FAIL rst_mid_out got %h want 0", bus2.out); end
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", bus2.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    q2.delete();
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      cyc2(1'b0, 1'b0, '0, '0, '0, 1'b1, ok, x, d, ir, ov);
      if (x) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale got %0d want 0", stale); end
    a = rnd2(); b = rnd2(); c = rnd2();
    send_one2(1'b1, a, b, c, ok, lat, got);
    checks++; if (ok !== 1'b1 || lat != 3) begin errors++; $display("FAIL rst_mid_latency got %b/%0d want 1/3", ok, lat); end
    checks++; if (got !== exp2(a, b, c, 1'b1)) begin errors++; $display("FAIL rst_mid_result got %h want %h", got, exp2(a, b, c, 1'b1)); end
  endtask

  task automatic test_back_to_back();
    mat2_t a, b, c;
    res2_t d, e;
    logic acc, have, ordy, ok, x, ir, ov;
    int sent, got;
    q2.delete(); sent = 0; got = 0; have = 1'b0; a = '0; b = '0; c = '0; acc = 1'b0;
    for (int k = 0; k < 2000 && got < 60; k++) begin
      if (!have && sent < 60 && $urandom_range(0, 3) != 0) begin
        a = rnd2(); b = rnd2(); c = rnd2(); acc = 1'($urandom_range(0, 1)); have = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      cyc2(have, acc, a, b, c, ordy, ok, x, d, ir, ov);
      checks++; if (ir !== (!ov || ordy)) begin errors++; $display("FAIL rand2_in_ready got %b want %b", ir, !ov || ordy); end
      if (x) begin
        checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL rand2_extra got %h want none", d); end
        else begin e = q2.pop_front(); if (d !== e) begin errors++; $display("FAIL rand2_data got %h want %h", d, e); end end
        got++;
      end
      if (ok) begin q2.push_back(exp2(a, b, c, acc)); sent++; have = 1'b0; end
    end
    checks++; if (got != 60 || q2.size() != 0) begin errors++; $display("FAIL rand2_count got %0d want 60", got); end
  endtask

  task automatic test_n3_regression();
    mat3_t a, b, c;
    res3_t d, e;
    logic acc, have, ordy, ok, x, ir, ov;
    int sent, got, lat;
    a = {9{16'h0001}};
    lat = -1; e = '0;
    cyc3(1'b1, 1'b0, a, a, '0, 1'b1, ok, x, d, ir, ov);
    for (int n = 1; n <= 8; n++) begin
      cyc3(1'b0, 1'b0, a, a, '0, 1'b1, have, x, d, ir, ov);
      if (x && lat < 0) begin lat = n; e = d; end
    end
    checks++; if (ok !== 1'b1 || lat != 3) begin errors++; $display("FAIL n3_ones_latency got %b/%0d want 1/3", ok, lat); end
    checks++; if (e[MW3-1:0] !== {9{16'd3}}) begin errors++; $display("FAIL n3_ones_c got %h want all 0003", e[MW3-1:0]); end

    q3.delete(); sent = 0; got = 0; have = 1'b0; a = '0; b = '0; c = '0; acc = 1'b0;
    for (int k = 0; k < 2000 && got < 100; k++) begin
      if (!have && sent < 100 && $urandom_range(0, 3) != 0) begin
        a = rnd3(); b = rnd3(); c = rnd3(); acc = 1'($urandom_range(0, 1)); have = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      cyc3(have, acc, a, b, c, ordy, ok, x, d, ir, ov);
      if (x) begin
        checks++;
        if (q3.size() == 0) begin errors++; $display("FAIL n3_extra got %h want none", d); end
        else begin e = q3.pop_front(); if (d !== e) begin errors++; $display("FAIL n3_data got %h want %h", d, e); end end
        got++;
      end
      if (ok) begin q3.push_back(exp3(a, b, c, acc)); sent++; have = 1'b0; end
    end
    checks++; if (got != 100 || q3.size() != 0) begin errors++; $display("FAIL n3_count got %0d want 100", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_wrap();
    test_accumulate();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    test_n3_regression();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
